// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle core: sequencer states, instruction
// class encodings, ALU operation codes and the HALT opcode.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [1:0] CLS_REG = 2'b00;
  localparam logic [1:0] CLS_IMM = 2'b01;
  localparam logic [1:0] CLS_MEM = 2'b10;
  localparam logic [1:0] CLS_BR  = 2'b11;

  localparam logic [5:0] OPC_HALT = 6'b111111;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SHL = 4'd5;
  localparam logic [3:0] ALU_SHR = 4'd6;
  localparam logic [3:0] ALU_SRA = 4'd7;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU; codes 8..15 pass operand b through, which is how the
// instruction set expresses register/literal moves.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result
);

  logic [4:0] shamt;

  assign shamt = b[4:0];

  always_comb begin
    result = b;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SHL: result = a << shamt;
      ALU_SHR: result = a >> shamt;
      ALU_SRA: result = $signed(a) >>> shamt;
      default: result = b;
    endcase
  end

endmodule

// File: rtl/cpu_datapath_mc.sv
// Multi-cycle core: fetch/decode/exec/mem/writeback sequencer, register file
// and PC, talking to memory over a request/acknowledge port.
module cpu_datapath_mc
  import cpu_pkg::*;
#(
  parameter int                WIDTH    = 32,
  parameter int                AWIDTH   = 32,
  parameter int                NREGS    = 32,
  parameter logic [AWIDTH-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  input  logic              mem_ack,
  output logic              halted,
  output logic [AWIDTH-1:0] pc_out
);

  localparam int RBITS = $clog2(NREGS);

  state_t            state;
  state_t            state_next;
  logic              run;
  logic [AWIDTH-1:0] pc;
  logic [AWIDTH-1:0] pc_inc;
  logic [AWIDTH-1:0] ea;
  logic [31:0]       ir;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic [WIDTH-1:0]  res;
  logic [WIDTH-1:0]  regs [NREGS];

  logic [5:0]        opcode;
  logic [1:0]        cls;
  logic [RBITS-1:0]  ra_idx;
  logic [RBITS-1:0]  rb_idx;
  logic [15:0]       lit;
  logic [WIDTH-1:0]  lit_w;
  logic [AWIDTH-1:0] lit_a;
  logic              is_store;
  logic              br_taken;
  logic              ack_ok;
  logic [WIDTH-1:0]  alu_b;
  logic [WIDTH-1:0]  alu_result;

  assign opcode   = ir[31:26];
  assign cls      = opcode[5:4];
  assign ra_idx   = ir[21 +: RBITS];
  assign rb_idx   = ir[16 +: RBITS];
  assign lit      = ir[15:0];
  assign lit_w    = WIDTH'($signed(lit));
  assign lit_a    = AWIDTH'($signed(lit));
  assign is_store = opcode[0];
  assign br_taken = ~opcode[0] | a[WIDTH-1];
  assign pc_inc   = pc + AWIDTH'(1);
  assign alu_b    = (cls == CLS_IMM) ? lit_w : b;

  // run stays low through reset so every memory output shows its reset value
  // and no request can start until the cycle after reset is released.
  assign mem_req   = run & ((state == S_FETCH) | (state == S_MEM));
  assign mem_we    = run & (state == S_MEM) & is_store;
  assign mem_addr  = !run ? '0 : ((state == S_MEM) ? ea : pc);
  assign mem_wdata = mem_we ? b : '0;
  assign ack_ok    = mem_req & mem_ack;
  assign halted    = (state == S_HALT);
  assign pc_out    = pc;

  cpu_alu #(.WIDTH(WIDTH)) u_alu (
    .a      (a),
    .b      (alu_b),
    .op     (opcode[3:0]),
    .result (alu_result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      run   <= 1'b0;
    end else begin
      state <= state_next;
      run   <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  if (ack_ok) state_next = S_DECODE;
      S_DECODE: state_next = (opcode == OPC_HALT) ? S_HALT : S_EXEC;
      S_EXEC: begin
        case (cls)
          CLS_MEM: state_next = S_MEM;
          CLS_BR:  state_next = S_FETCH;
          default: state_next = S_WB;
        endcase
      end
      S_MEM:    if (ack_ok) state_next = is_store ? S_FETCH : S_WB;
      S_WB:     state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_FETCH;
    endcase
  end

  // r0 is never written, so its reset value keeps it reading as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc  <= RESET_PC;
      ir  <= '0;
      a   <= '0;
      b   <= '0;
      res <= '0;
      ea  <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: if (ack_ok) ir <= mem_rdata[31:0];
        S_DECODE: begin
          a <= regs[ra_idx];
          b <= regs[rb_idx];
        end
        S_EXEC: begin
          case (cls)
            CLS_MEM: ea <= AWIDTH'(a) + lit_a;
            CLS_BR:  pc <= br_taken ? (pc + lit_a) : pc_inc;
            default: res <= alu_result;
          endcase
        end
        S_MEM: begin
          if (ack_ok) begin
            if (is_store) pc <= pc_inc;
            else          res <= mem_rdata;
          end
        end
        S_WB: begin
          if (ra_idx != '0) regs[ra_idx] <= res;
          pc <= pc_inc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_datapath_mc.sv
// Bench for cpu_datapath_mc: an instruction-level model predicts every memory
// transaction, and a monitor compares each completed handshake against it.
module tb_cpu_datapath_mc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        halted;
  logic [31:0] pc_out;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          fetch;
  } txn_t;

  logic [31:0] tbmem [256];
  txn_t        exp_q [$];
  int          checks = 0;
  int          errors = 0;
  int          wait_fixed = 0;
  int          model_lat = 0;
  logic [31:0] model_pc = '0;
  int          last_cycles = 0;

  cpu_datapath_mc #(
    .WIDTH(32), .AWIDTH(32), .NREGS(32), .RESET_PC(32'h0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .halted    (halted),
    .pc_out    (pc_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] enc(input logic [5:0] op, input int ra, input int rb, input int lit);
    enc = {op, ra[4:0], rb[4:0], lit[15:0]};
  endfunction

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    case (op)
      4'd0:    return x + y;
      4'd1:    return x - y;
      4'd2:    return x & y;
      4'd3:    return x | y;
      4'd4:    return x ^ y;
      4'd5:    return x << y[4:0];
      4'd6:    return x >> y[4:0];
      4'd7:    return $signed(x) >>> y[4:0];
      default: return y;
    endcase
  endfunction

  // Instruction-level interpreter over a private copy of memory; each access
  // it makes becomes one expected transaction, and it tallies the zero-wait latency.
  task automatic runModel();
    logic [31:0] r [32];
    logic [31:0] m [256];
    logic [31:0] pc, ins, litx, bv, addr;
    logic [5:0]  opc;
    logic [4:0]  fa, fb;
    for (int i = 0; i < 32; i++) r[i] = '0;
    m = tbmem;
    pc = '0;
    model_lat = 0;
    for (int step = 0; step < 4000; step++) begin
      exp_q.push_back('{we: 1'b0, addr: pc, wdata: 32'h0, fetch: 1'b1});
      ins  = m[pc[7:0]];
      opc  = ins[31:26];
      fa   = ins[25:21];
      fb   = ins[20:16];
      litx = {{16{ins[15]}}, ins[15:0]};
      if (opc == 6'h3F) break;
      case (opc[5:4])
        2'b00, 2'b01: begin
          bv = opc[4] ? litx : r[fb];
          if (fa != 0) r[fa] = alu_ref(opc[3:0], r[fa], bv);
          pc = pc + 1;
          model_lat += 4;
        end
        2'b10: begin
          addr = r[fa] + litx;
          if (opc[0]) begin
            exp_q.push_back('{we: 1'b1, addr: addr, wdata: r[fb], fetch: 1'b0});
            m[addr[7:0]] = r[fb];
            model_lat += 4;
          end else begin
            exp_q.push_back('{we: 1'b0, addr: addr, wdata: 32'h0, fetch: 1'b0});
            if (fa != 0) r[fa] = m[addr[7:0]];
            model_lat += 5;
          end
          pc = pc + 1;
        end
        default: begin
          if (!opc[0] || r[fa][31]) pc = pc + litx;
          else pc = pc + 1;
          model_lat += 3;
        end
      endcase
    end
    model_pc = pc;
  endtask

  // Memory responder: acks after cur_wait cycles of an outstanding request.
  int cnt = 0;
  int cur_wait = 0;
  bit started = 1'b0;
  always @(posedge clk) begin
    #1;
    if (mem_ack) started = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = $urandom;
    if (mem_req) begin
      if (!started) begin
        started = 1'b1;
        cnt = 0;
        cur_wait = (wait_fixed < 0) ? int'($urandom_range(0, 3)) : wait_fixed;
      end
      if (cnt >= cur_wait) begin
        mem_ack = 1'b1;
        mem_rdata = tbmem[mem_addr[7:0]];
      end else begin
        cnt++;
      end
    end else begin
      started = 1'b0;
    end
  end

  // Monitor: every handshake that completes at the coming edge is checked.
  txn_t t;
  always @(negedge clk) begin
    if (!reset && mem_req && mem_ack) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected request: addr 0x%0h we %0b, expected none", mem_addr, mem_we);
      end else begin
        t = exp_q.pop_front();
        checkOutput("mem_we", 64'(mem_we), 64'(t.we));
        checkOutput("mem_addr", 64'(mem_addr), 64'(t.addr));
        if (t.we) checkOutput("mem_wdata", 64'(mem_wdata), 64'(t.wdata));
        if (t.fetch) checkOutput("pc_out at fetch", 64'(pc_out), 64'(t.addr));
      end
      if (mem_we) tbmem[mem_addr[7:0]] = mem_wdata;
    end
  end

  task automatic holdReset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic clearMem();
    for (int i = 0; i < 256; i++) tbmem[i] = (i >= 128) ? $urandom : 32'h0;
  endtask

  // Releases reset on the loaded program and runs it to HALT.
  task automatic applyStimulus(input string name, input int budget);
    int n = 0;
    runModel();
    reset = 1'b0;
    while (!halted && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    last_cycles = n;
    checkOutput({name, " halted"}, 64'(halted), 64'd1);
    @(negedge clk);
    checkOutput({name, " transactions left"}, 64'(exp_q.size()), 64'd0);
    checkOutput({name, " final pc"}, 64'(pc_out), 64'(model_pc));
  endtask

  initial begin
    int seen, found, p, k;
    logic [31:0] saved;

    clearMem();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset mem_req", 64'(mem_req), 64'd0);
    checkOutput("reset mem_we", 64'(mem_we), 64'd0);
    checkOutput("reset mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("reset mem_wdata", 64'(mem_wdata), 64'd0);
    checkOutput("reset halted", 64'(halted), 64'd0);
    checkOutput("reset pc_out", 64'(pc_out), 64'd0);

    holdReset();
    wait_fixed = 2;
    tbmem[0]  = enc(6'h10, 1, 0, 5);
    tbmem[1]  = enc(6'h08, 2, 1, 0);
    tbmem[2]  = enc(6'h11, 2, 0, 7);
    tbmem[3]  = enc(6'h08, 3, 2, 0);
    tbmem[4]  = enc(6'h17, 3, 0, 1);
    tbmem[5]  = enc(6'h10, 0, 0, 9);
    tbmem[6]  = enc(6'h10, 2, 0, 1);
    tbmem[7]  = enc(6'h21, 0, 2, 16'h11);
    tbmem[8]  = enc(6'h31, 2, 0, -2);
    tbmem[9]  = enc(6'h31, 1, 0, -2);
    tbmem[10] = enc(6'h21, 0, 1, 16'h10);
    tbmem[11] = enc(6'h20, 4, 0, 16'h10);
    tbmem[12] = enc(6'h21, 0, 3, 16'h12);
    tbmem[13] = enc(6'h21, 0, 4, 16'h13);
    tbmem[14] = enc(6'h21, 0, 0, 16'h14);
    tbmem[15] = enc(6'h30, 0, 0, 2);
    tbmem[16] = enc(6'h10, 5, 0, 1);
    tbmem[17] = enc(6'h21, 0, 5, 16'h15);
    tbmem[18] = enc(6'h3F, 0, 0, 0);
    applyStimulus("directed", 3000);
    checkOutput("r2 stored at 0x11", 64'(tbmem[8'h11]), 64'h0);
    checkOutput("r1 stored at 0x10", 64'(tbmem[8'h10]), 64'd5);
    checkOutput("r3 stored at 0x12", 64'(tbmem[8'h12]), 64'hFFFFFFFF);
    checkOutput("r4 stored at 0x13", 64'(tbmem[8'h13]), 64'd5);
    checkOutput("r0 stored at 0x14", 64'(tbmem[8'h14]), 64'd0);
    checkOutput("skipped r5 at 0x15", 64'(tbmem[8'h15]), 64'd0);
    checkOutput("directed pc after halt", 64'(pc_out), 64'd18);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_req) seen++;
    end
    checkOutput("requests while halted", 64'(seen), 64'd0);
    checkOutput("halted held", 64'(halted), 64'd1);

    holdReset();
    checkOutput("halted cleared by reset", 64'(halted), 64'd0);
    clearMem();
    wait_fixed = 3;
    tbmem[0] = enc(6'h10, 1, 0, 16'h11);
    tbmem[1] = enc(6'h10, 2, 0, 16'h22);
    tbmem[2] = enc(6'h21, 0, 1, 16'h80);
    tbmem[3] = enc(6'h3F, 0, 0, 0);
    saved = tbmem[8'h80];
    runModel();
    reset = 1'b0;
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      @(posedge clk);
      #2;
      if (mem_req && mem_we) found = 1;
    end
    checkOutput("store reached MEM", 64'(found), 64'd1);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    checkOutput("mem_req after mid-MEM reset", 64'(mem_req), 64'd0);
    checkOutput("pc_out after mid-MEM reset", 64'(pc_out), 64'd0);
    checkOutput("abandoned store", 64'(tbmem[8'h80]), 64'(saved));

    holdReset();
    clearMem();
    wait_fixed = -1;
    for (int r = 1; r < 8; r++) tbmem[r-1] = enc(6'h21, 0, r, 16'h90 + r);
    tbmem[7] = enc(6'h3F, 0, 0, 0);
    applyStimulus("registers zero after reset", 3000);

    for (int iter = 0; iter < 4; iter++) begin
      holdReset();
      clearMem();
      wait_fixed = (iter == 3) ? 0 : -1;
      p = 0;
      for (int i = 0; i < 24; i++) begin
        k = $urandom_range(0, 9);
        if (k <= 6) begin
          tbmem[p] = enc({1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15))},
                         $urandom_range(0, 7), $urandom_range(0, 7), $urandom);
          p++;
        end else if (k == 7) begin
          k = $urandom_range(1, 7);
          tbmem[p] = enc(6'h08, k, 0, 0);
          tbmem[p+1] = enc(6'h20, k, 0, 16'h80 + $urandom_range(0, 15));
          p += 2;
        end else if (k == 8) begin
          tbmem[p] = enc(6'h21, 0, $urandom_range(0, 7), 16'h80 + $urandom_range(0, 15));
          p++;
        end else begin
          tbmem[p] = enc({5'b11000, 1'($urandom_range(0, 1))}, $urandom_range(0, 7), 0, 2);
          p++;
        end
      end
      for (int r = 1; r < 8; r++) begin
        tbmem[p] = enc(6'h21, 0, r, 16'hA0 + r);
        p++;
      end
      tbmem[p] = enc(6'h3F, 0, 0, 0);
      applyStimulus("random program", 5000);
      if (iter == 3) checkOutput("zero-wait cycle count", 64'(last_cycles), 64'(model_lat + 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_datapath_mc.md
# cpu_datapath_mc

Multi-cycle CPU core that generalises the existing single-path datapath. It replaces the tri-state address and data buses with a request/acknowledge memory port, and adds an internal instruction sequencer. The register count and data/address widths are parametrised. The block fetches, decodes, executes and retires one instruction at a time, and tolerates memory wait states of any length. It sits between the instruction/data memory arbiter and the top-level debug logic.

## Interface
Parameters:
- WIDTH, 32, datapath and register width; must be at least 32.
- AWIDTH, 32, memory address width (word addressed).
- NREGS, 32, number of general registers; power of two, at most 32.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_req  out  1  memory request, held high until acknowledged.
- mem_we  out  1  1 = store, 0 = read (fetch or load).
- mem_addr  out  AWIDTH  request address.
- mem_wdata  out  WIDTH  store data.
- mem_rdata  in  WIDTH  read data, valid in the mem_ack cycle.
- mem_ack  in  1  completes the request in the current cycle.
- halted  out  1  core has executed HALT.
- pc_out  out  AWIDTH  current PC, for debug.

## Operation
- Instruction word (low 32 bits of mem_rdata):
  - [31:26] opcode
  - [25:21] ra/rd
  - [20:16] rb
  - [15:0] literal, signed; sign-extended to WIDTH (or AWIDTH)
  - Register index uses the low log2(NREGS) bits of ra/rb.
- opcode[5:4] selects the instruction class:
  - 00: rd = ra OP rb
  - 01: rd = ra OP literal
  - 10: memory. opcode[0]=0 is a load: rd = mem[ra + literal]. opcode[0]=1 is a store: mem[ra + literal] = rb.
  - 11: branch. opcode[0]=0 branches unconditionally. opcode[0]=1 branches if ra[WIDTH-1]=1.
  - opcode 6'b111111 is HALT.
- OP is opcode[3:0]:
  - 0 add, 1 sub, 2 and, 3 or, 4 xor
  - 5 shl, 6 shr (logical; shift amount is the low 5 bits of B)
  - 7 sra
  - 8..15: result = B
- Arithmetic wraps modulo 2^WIDTH; there is no carry or overflow flag. Effective addresses and branch targets wrap modulo 2^AWIDTH.
- r0 reads as zero; writes to r0 are discarded.
- States:
  - FETCH: mem_req=1, mem_we=0, mem_addr=PC. On mem_ack, latch IR and go to DECODE.
  - DECODE: latch A=reg[ra] and B=reg[rb]. HALT goes to HALT; everything else goes to EXEC.
  - EXEC: compute the ALU result or the effective address. Memory class goes to MEM. Taken branch: PC=PC+sext(literal). Not-taken branch: PC=PC+1. Branches then go to FETCH; all others go to WB.
  - MEM: mem_req=1 with mem_addr = effective address; mem_wdata=B for stores. On mem_ack, latch read data; stores go to FETCH with PC+1, loads go to WB.
  - WB: write rd, PC+1, go to FETCH.
  - HALT: halted=1; stays in HALT until reset.
- Outside FETCH and MEM, mem_req=0. mem_ack is ignored whenever mem_req=0.
- While mem_req is high, mem_addr, mem_we and mem_wdata are stable.

## Timing
- Reset values:
  - state=FETCH, PC=RESET_PC, all registers 0
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0
  - halted=0, pc_out=RESET_PC
- mem_req first asserts in the first cycle after reset deasserts.
- Latency with zero-wait memory (ack in the same cycle as req):
  - ALU instruction: 4 cycles
  - Branch: 3 cycles
  - Store: 4 cycles
  - Load: 5 cycles
  - Each wait cycle adds 1.
- A register write in WB is visible to the DECODE of the next instruction.
- Reset asserted mid-FETCH or mid-MEM: mem_req=0 on the next edge, the in-flight request is abandoned, and no register or PC update occurs.
- Ack in the same cycle that reset is asserted: the ack is ignored.

## Structure
- Shared package cpu_pkg holds:
  - state enum
  - opcode class constants
  - ALU op encodings
  - HALT opcode constant
- Sub-module cpu_alu is purely combinational: operands A and B, 4-bit op, WIDTH-bit result.
- The register file, sequencer and PC live in cpu_datapath_mc.

## Test plan
- Reset, then 3-cycle-latency ack on every request → first mem_req has mem_addr=0; fetch completes on the 3rd req cycle; pc_out=1 after the first instruction retires.
- Program: r1 = r0 + 5, r2 = r1 - 7, r3 = r2 sra 1 → r1=5, r2=0xFFFFFFFE, r3=0xFFFFFFFF; a write to r0 leaves r0 reading 0.
- Store r1 to [r0+0x10], then load r4 from [r0+0x10] with 2 wait states → store cycle shows mem_we=1, addr=0x10, wdata=5; afterwards r4=5.
- Branch if negative on r2 with literal -2 at PC=8 → next fetch address is 6. Same branch with r1 (positive) → next fetch address is 9.
- Assert reset during a MEM wait → mem_req=0 on the next cycle; state is FETCH at RESET_PC; all registers are 0.
- HALT → halted=1 and mem_req stays 0 for 20 cycles; reset clears halted.
